// File: rtl/buf_arb_pkg.sv
// buf_arb_pkg: shared sizes and requester encoding for the buffer arbiter.
package buf_arb_pkg;
  localparam int BUF_DEPTH = 64;
  localparam int ADDR_W = 6;
  localparam int OCC_W = 7;
  typedef enum logic [2:0] {
    REQ_RX_WR,
    REQ_TX_RD,
    REQ_AHB_WR,
    REQ_AHB_RD,
    REQ_NONE
  } req_e;
  function automatic logic is_wr(req_e r);
    return (r == REQ_RX_WR) || (r == REQ_AHB_WR);
  endfunction
  function automatic logic is_rd(req_e r);
    return (r == REQ_TX_RD) || (r == REQ_AHB_RD);
  endfunction
endpackage

// File: rtl/buf_arb_ptr.sv
// buf_arb_ptr: circular-FIFO write/read pointers and occupancy for buf_arb.
module buf_arb_ptr
  import buf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic              rd,
  output logic [ADDR_W-1:0] wp,
  output logic [ADDR_W-1:0] rp,
  output logic [OCC_W-1:0]  occ,
  output logic              full,
  output logic              empty
);
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  always_comb begin
    wp_d  = clr ? '0 : wr ? wp_q + ADDR_W'(1) : wp_q;
    rp_d  = clr ? '0 : rd ? rp_q + ADDR_W'(1) : rp_q;
    occ_d = clr ? '0 : wr ? occ_q + OCC_W'(1) : rd ? occ_q - OCC_W'(1) : occ_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
  end
  assign wp    = wp_q;
  assign rp    = rp_q;
  assign occ   = occ_q;
  assign full  = occ_q == OCC_W'(BUF_DEPTH);
  assign empty = occ_q == '0;
endmodule

// File: rtl/buf_arb.sv
// buf_arb: fixed-priority arbiter sharing a 64x8 single-port RAM as a FIFO between USB and AHB.
// Define BUF_ARB_STATS_EN to add the saturating drop_cnt output.
module buf_arb
  import buf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_wr_req,
  input  logic [7:0]        rx_wr_data,
  output logic              rx_wr_ack,
  input  logic              tx_rd_req,
  output logic              tx_rd_valid,
  output logic [7:0]        tx_rd_data,
  input  logic              ahb_wr_req,
  input  logic [7:0]        ahb_wr_data,
  output logic              ahb_wr_ack,
  input  logic              ahb_rd_req,
  output logic              ahb_rd_valid,
  output logic [7:0]        ahb_rd_data,
  input  logic              flush,
  input  logic              clear,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [OCC_W-1:0]  occupancy,
  output logic              overflow_err,
  output logic              underflow_err
`ifdef BUF_ARB_STATS_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);
  req_e gnt;
  logic kill, clr, full, empty, wr, rd;
  logic rx_ok, tx_ok, aw_ok, ar_ok;
  logic [ADDR_W-1:0] wp, rp;
  logic last_ahb_q, last_ahb_d, tx_pend_q, tx_pend_d, ahb_pend_q, ahb_pend_d;
  buf_arb_ptr u_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .wr    (wr),
    .rd    (rd),
    .wp    (wp),
    .rp    (rp),
    .occ   (occupancy),
    .full  (full),
    .empty (empty)
  );
  // A dropped RX write or refused TX read does not consume the cycle's RAM slot.
  always_comb begin
    clr   = flush | clear;
    kill  = rst | clr;
    rx_ok = rx_wr_req & ~full;
    tx_ok = tx_rd_req & ~empty;
    aw_ok = ahb_wr_req & ~full;
    ar_ok = ahb_rd_req & ~empty;
    gnt   = kill ? REQ_NONE :
            rx_ok ? REQ_RX_WR :
            tx_ok ? REQ_TX_RD :
            (aw_ok && (!ar_ok || !last_ahb_q)) ? REQ_AHB_WR :
            ar_ok ? REQ_AHB_RD : REQ_NONE;
    wr    = is_wr(gnt);
    rd    = is_rd(gnt);
    mem_en    = gnt != REQ_NONE;
    mem_we    = wr;
    mem_addr  = wr ? wp : rd ? rp : '0;
    mem_wdata = (gnt == REQ_RX_WR) ? rx_wr_data : (gnt == REQ_AHB_WR) ? ahb_wr_data : '0;
    rx_wr_ack     = gnt == REQ_RX_WR;
    ahb_wr_ack    = gnt == REQ_AHB_WR;
    overflow_err  = ~kill & rx_wr_req & full;
    underflow_err = ~kill & tx_rd_req & empty;
    last_ahb_d = (gnt == REQ_AHB_WR || gnt == REQ_AHB_RD) ? ~last_ahb_q : last_ahb_q;
    tx_pend_d  = gnt == REQ_TX_RD;
    ahb_pend_d = gnt == REQ_AHB_RD;
    tx_rd_valid  = tx_pend_q & ~rst;
    ahb_rd_valid = ahb_pend_q & ~rst;
    tx_rd_data   = tx_rd_valid ? mem_rdata : '0;
    ahb_rd_data  = ahb_rd_valid ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ahb_q <= 1'b0;
      tx_pend_q  <= 1'b0;
      ahb_pend_q <= 1'b0;
    end else begin
      last_ahb_q <= last_ahb_d;
      tx_pend_q  <= tx_pend_d;
      ahb_pend_q <= ahb_pend_d;
    end
  end
`ifdef BUF_ARB_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb drop_cnt_d = (overflow_err && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_buf_arb.sv
// tb_buf_arb: scoreboard bench for buf_arb against a queue-based FIFO reference model.
module tb_buf_arb;
  logic clk = 0, rst = 1;
  logic rx_wr_req = 0, tx_rd_req = 0, ahb_wr_req = 0, ahb_rd_req = 0, flush = 0, clear = 0;
  logic [7:0] rx_wr_data = 0, ahb_wr_data = 0, mem_rdata = 0;
  logic rx_wr_ack, tx_rd_valid, ahb_wr_ack, ahb_rd_valid, mem_en, mem_we, overflow_err, underflow_err;
  logic [7:0] tx_rd_data, ahb_rd_data, mem_wdata;
  logic [5:0] mem_addr;
  logic [6:0] occupancy;
`ifdef BUF_ARB_STATS_EN
  logic [15:0] drop_cnt;
`endif
  logic [7:0] ram [64];

  buf_arb dut (
    .clk(clk), .rst(rst),
    .rx_wr_req(rx_wr_req), .rx_wr_data(rx_wr_data), .rx_wr_ack(rx_wr_ack),
    .tx_rd_req(tx_rd_req), .tx_rd_valid(tx_rd_valid), .tx_rd_data(tx_rd_data),
    .ahb_wr_req(ahb_wr_req), .ahb_wr_data(ahb_wr_data), .ahb_wr_ack(ahb_wr_ack),
    .ahb_rd_req(ahb_rd_req), .ahb_rd_valid(ahb_rd_valid), .ahb_rd_data(ahb_rd_data),
    .flush(flush), .clear(clear),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .occupancy(occupancy), .overflow_err(overflow_err), .underflow_err(underflow_err)
`ifdef BUF_ARB_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    bit rx_ack, ahb_ack, ovf, unf, en, we, g_tx, g_ar;
    bit [5:0] addr;
    int occ;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] fifo[$], exp_tx[$], exp_ahb[$];
  int checks = 0, failures = 0, drops = 0, wp_m = 0, rp_m = 0;
  bit last = 0, prev_tx = 0, prev_ar = 0;
  bit g_rx, g_tx, g_aw, g_ar, m_ovf, m_unf;

  task automatic chk(string n, int act, int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, expv, $time);
    end
  endtask

  // Drive one cycle of requests, predict the response from the FIFO contents, advance.
  task automatic step(bit rxr, logic [7:0] rxd, bit txr, bit awr, logic [7:0] awd, bit arr, bit fl, bit cl);
    exp_t e;
    int occ;
    rx_wr_req = rxr; rx_wr_data = rxd; tx_rd_req = txr;
    ahb_wr_req = awr; ahb_wr_data = awd; ahb_rd_req = arr; flush = fl; clear = cl;
    occ = fifo.size();
    e = '0;
    e.occ = occ;
    {g_rx, g_tx, g_aw, g_ar, m_ovf, m_unf} = '0;
    if (fl || cl) begin
      fifo.delete();
      wp_m = 0;
      rp_m = 0;
    end else begin
      m_ovf = rxr && occ == 64;
      m_unf = txr && occ == 0;
      if (rxr && occ < 64) g_rx = 1;
      else if (txr && occ > 0) g_tx = 1;
      else if (awr && occ < 64 && !(arr && occ > 0 && last)) g_aw = 1;
      else if (arr && occ > 0) g_ar = 1;
      if (g_rx || g_aw) begin
        e.we = 1;
        e.addr = 6'(wp_m);
        fifo.push_back(g_rx ? rxd : awd);
        wp_m = (wp_m + 1) % 64;
      end
      if (g_tx || g_ar) begin
        e.addr = 6'(rp_m);
        rp_m = (rp_m + 1) % 64;
        if (g_tx) exp_tx.push_back(fifo.pop_front());
        else exp_ahb.push_back(fifo.pop_front());
      end
      if (g_aw || g_ar) last = !last;
      if (m_ovf && drops < 65535) drops++;
    end
    e.rx_ack = g_rx; e.ahb_ack = g_aw; e.ovf = m_ovf; e.unf = m_unf;
    e.en = g_rx | g_tx | g_aw | g_ar; e.g_tx = g_tx; e.g_ar = g_ar;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rx_wr_ack", int'(rx_wr_ack), int'(e.rx_ack));
      chk("ahb_wr_ack", int'(ahb_wr_ack), int'(e.ahb_ack));
      chk("overflow_err", int'(overflow_err), int'(e.ovf));
      chk("underflow_err", int'(underflow_err), int'(e.unf));
      chk("mem_en", int'(mem_en), int'(e.en));
      chk("mem_we", int'(mem_we), int'(e.we));
      if (e.en) chk("mem_addr", int'(mem_addr), int'(e.addr));
      chk("occupancy", int'(occupancy), e.occ);
      chk("tx_rd_valid", int'(tx_rd_valid), int'(prev_tx));
      chk("ahb_rd_valid", int'(ahb_rd_valid), int'(prev_ar));
      if (tx_rd_valid) begin
        if (exp_tx.size() == 0) chk("tx_spurious", 1, 0);
        else chk("tx_rd_data", int'(tx_rd_data), int'(exp_tx.pop_front()));
      end
      if (ahb_rd_valid) begin
        if (exp_ahb.size() == 0) chk("ahb_spurious", 1, 0);
        else chk("ahb_rd_data", int'(ahb_rd_data), int'(exp_ahb.pop_front()));
      end
      prev_tx = e.g_tx;
      prev_ar = e.g_ar;
    end
  end

  initial begin
    bit rx_p, tx_p, aw_p, ar_p, fl, cl;
    logic [7:0] rx_d, aw_d;
    int rx_pct, tx_pct;
    {rx_p, tx_p, aw_p, ar_p} = '0;
    rx_d = 0;
    aw_d = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_acks", int'({rx_wr_ack, ahb_wr_ack}), 0);
    chk("rst_valids", int'({tx_rd_valid, ahb_rd_valid}), 0);
    chk("rst_rd_data", int'({tx_rd_data, ahb_rd_data}), 0);
    chk("rst_errs", int'({overflow_err, underflow_err}), 0);
    @(posedge clk);
    #1 rst = 0;
    // AHB write/read contention at occupancy 10: W,R,W,R
    for (int i = 0; i < 10; i++) step(1, 8'(i), 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, 8'(8'h50 + i), 1, 0, 0);
    idle();
    // three writes then three reads
    step(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    step(1, 8'hA1, 0, 0, 8'h00, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 8'h00, 0, 0, 0);
    step(1, 8'hA3, 0, 0, 8'h00, 0, 0, 0);
    repeat (3) step(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    idle();
    // three-way contention at occupancy 5
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0, 8'h00, 0, 0, 0);
    step(1, 8'hB0, 1, 1, 8'hB1, 0, 0, 0);
    step(0, 8'h00, 1, 1, 8'hB1, 0, 0, 0);
    step(0, 8'h00, 0, 1, 8'hB1, 0, 0, 0);
    idle();
    chk("occ_after_contention", int'(occupancy), 6);
    // full buffer: RX drop, AHB write waits for a TX read
    step(0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 64; i++) step(1, 8'($urandom), 0, 0, 8'h00, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 1, 8'hC3, 0, 0, 0);
    step(0, 8'h00, 0, 1, 8'hC3, 0, 0, 0);
    idle();
    // flush beats a simultaneous RX write at occupancy 20
    step(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 8'($urandom), 0, 0, 8'h00, 0, 0, 0);
    step(1, 8'hDD, 0, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    // 70 interleaved writes/reads wrap both pointers
    for (int i = 0; i < 70; i++) begin
      step(1, 8'(i * 3 + 1), 0, 0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    end
    idle();
    // reset while a read is in flight: no valid may follow
    step(1, 8'h77, 0, 0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tx_rd_req = 0;
    rst = 1;
    @(negedge clk);
    chk("rst_abandon_valid", int'(tx_rd_valid), 0);
    @(posedge clk);
    #1 rst = 0;
    fifo.delete(); exp_tx.delete(); exp_ahb.delete();
    last = 0; wp_m = 0; rp_m = 0; drops = 0; prev_tx = 0; prev_ar = 0;
    @(negedge clk);
    chk("post_rst_valid", int'(tx_rd_valid), 0);
    chk("post_rst_occupancy", int'(occupancy), 0);
    @(posedge clk);
    #1;
    // randomized traffic with requesters holding until served
    for (int c = 0; c < 2000; c++) begin
      rx_pct = (c % 400 < 200) ? 60 : 15;
      tx_pct = (c % 400 < 200) ? 10 : 40;
      if (!rx_p) begin rx_p = $urandom_range(0, 99) < rx_pct; rx_d = 8'($urandom); end
      if (!tx_p) tx_p = $urandom_range(0, 99) < tx_pct;
      if (!aw_p) begin aw_p = $urandom_range(0, 99) < 25; aw_d = 8'($urandom); end
      if (!ar_p) ar_p = $urandom_range(0, 99) < 25;
      fl = $urandom_range(0, 199) == 0;
      cl = $urandom_range(0, 199) == 0;
      step(rx_p, rx_d, tx_p, aw_p, aw_d, ar_p, fl, cl);
      if (fl || cl) {rx_p, tx_p, aw_p, ar_p} = '0;
      else begin
        if (g_rx || m_ovf) rx_p = 0;
        if (g_tx || m_unf) tx_p = 0;
        if (g_aw) aw_p = 0;
        if (g_ar) ar_p = 0;
      end
    end
    repeat (2) idle();
    @(negedge clk);
    chk("tx_left", exp_tx.size(), 0);
    chk("ahb_left", exp_ahb.size(), 0);
`ifdef BUF_ARB_STATS_EN
    chk("drop_cnt", int'(drop_cnt), drops);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
